// File: rtl/alu_seq_pkg.sv
// Package: alu_seq_pkg
// Shared types and constants for the alu_seq_ctrl sequencer and its shared adder.
//   alu_op_e    : opcode encoding as presented on the opcode port
//   seq_state_e : sequencer FSM states
//   SAT_POS/NEG : 16-bit saturation limits
//   sext8       : sign-extend a signed byte to 16 bits (RED byte lanes)
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD    = 3'b000,
      OP_SUB    = 3'b001,
      OP_XOR    = 3'b010,
      OP_RED    = 3'b011,
      OP_SLL    = 3'b100,
      OP_SRA    = 3'b101,
      OP_ROR    = 3'b110,
      OP_PADDSB = 3'b111
   } alu_op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      EXEC = 3'd1,
      RED1 = 3'd2,
      RED2 = 3'd3,
      RED3 = 3'd4,
      DONE = 3'd5
   } seq_state_e;

   localparam logic [15:0] SAT_POS = 16'h7FFF;
   localparam logic [15:0] SAT_NEG = 16'h8000;

   function automatic logic [15:0] sext8(input logic [7:0] b);
      return {{8{b[7]}}, b};
   endfunction

endpackage

// File: rtl/seq_shared_adder.sv
// Module: seq_shared_adder
// Combinational 16-bit two's-complement adder/subtractor with optional saturation.
// Ports:
//   a, b  in  DW  operands
//   sub   in  1   1: compute a + ~b + cin (use cin=1 for a true subtract)
//   sat   in  1   1: clamp signed overflow to SAT_POS/SAT_NEG
//   cin   in  1   carry in
//   sum   out DW  result (saturated when sat=1 and overflow occurred)
//   ovfl  out 1   saturation applied
module seq_shared_adder
   import alu_seq_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          sub,
   input  logic          sat,
   input  logic          cin,
   output logic [DW-1:0] sum,
   output logic          ovfl
);

   logic [DW-1:0] b_eff;
   logic [DW-1:0] raw_sum;
   logic          ovf_raw;

   assign b_eff   = sub ? ~b : b;
   assign raw_sum = a + b_eff + {{(DW-1){1'b0}}, cin};

   // Overflow when both addends share a sign the sum does not. Using b_eff
   // (not b) keeps this correct for subtract, including b = most-negative.
   assign ovf_raw = (a[DW-1] == b_eff[DW-1]) && (raw_sum[DW-1] != a[DW-1]);
   assign ovfl    = sat && ovf_raw;
   assign sum     = ovfl ? (a[DW-1] ? SAT_NEG : SAT_POS) : raw_sum;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Module: alu_seq_ctrl
// One-op-at-a-time sequencer for the 16-bit compute datapath. Single-cycle ops
// (ADD/SUB/XOR/SLL/SRA/ROR/PADDSB) finish one cycle after accept; RED takes three
// steps through the shared adder. The result is held until out_ready.
// Build option: define ALU_SEQ_FLAGS_EN to get the {Z,V,N} flag register;
// otherwise flags is tied to 3'b000.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   op handshake (in_ready high only in IDLE)
//   opcode, rs, rt, imm4  op and operands, latched on accept
//   out_valid/out_ready result handshake
//   result, ovfl, flags registered outputs
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int DW  = 16,
   parameter int SHW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2:0]     opcode,
   input  logic [DW-1:0]  rs,
   input  logic [DW-1:0]  rt,
   input  logic [SHW-1:0] imm4,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DW-1:0]  result,
   output logic           ovfl,
   output logic [2:0]     flags
);

   seq_state_e     state_reg;
   alu_op_e        op_reg;
   logic [DW-1:0]  rs_reg, rt_reg;
   logic [SHW-1:0] imm_reg;
   logic [DW-1:0]  t0_reg, t1_reg;
   logic [DW-1:0]  result_reg;
   logic           ovfl_reg, out_valid_reg, in_ready_reg;

   // Shared adder steering: EXEC uses it saturating for ADD/SUB, RED steps
   // use it as a plain adder on sign-extended partial sums.
   logic [DW-1:0] add_a, add_b, add_sum;
   logic          add_sub, add_sat, add_cin, add_ovfl;

   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_sub = 1'b0;
      add_sat = 1'b0;
      add_cin = 1'b0;
      case (state_reg)
         EXEC: begin
            add_a   = rs_reg;
            add_b   = rt_reg;
            add_sub = (op_reg == OP_SUB);
            add_cin = (op_reg == OP_SUB);
            add_sat = 1'b1;
         end
         RED1: begin
            add_a = sext8(rs_reg[15:8]);
            add_b = sext8(rs_reg[7:0]);
         end
         RED2: begin
            add_a = sext8(rt_reg[15:8]);
            add_b = sext8(rt_reg[7:0]);
         end
         RED3: begin
            add_a = t0_reg;
            add_b = t1_reg;
         end
         default: ;
      endcase
   end

   seq_shared_adder #(.DW(DW)) u_adder (
      .a    (add_a),
      .b    (add_b),
      .sub  (add_sub),
      .sat  (add_sat),
      .cin  (add_cin),
      .sum  (add_sum),
      .ovfl (add_ovfl)
   );

   // PADDSB: four independent 4-bit signed saturating lanes.
   logic [DW-1:0] padd_res;
   logic [3:0]    padd_ovf;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_padd
         logic [4:0] lane_sum;
         assign lane_sum = {rs_reg[4*gi+3], rs_reg[4*gi +: 4]} + {rt_reg[4*gi+3], rt_reg[4*gi +: 4]};
         assign padd_ovf[gi] = lane_sum[4] ^ lane_sum[3];
         assign padd_res[4*gi +: 4] = padd_ovf[gi] ? (lane_sum[4] ? 4'h8 : 4'h7) : lane_sum[3:0];
      end
   endgenerate

   // ROR: output bit i takes source bit (i + imm) mod DW; the 4-bit index wraps naturally.
   logic [DW-1:0] ror_res;

   generate
      for (genvar gi = 0; gi < DW; gi++) begin : g_ror
         localparam logic [SHW-1:0] BIT_IDX = SHW'(gi);
         assign ror_res[gi] = rs_reg[BIT_IDX + imm_reg];
      end
   endgenerate

   // Value that lands in result/ovfl on DONE entry (from EXEC or RED3).
   logic [DW-1:0] done_result;
   logic          done_ovfl;

   always_comb begin
      done_result = '0;
      done_ovfl   = 1'b0;
      if (state_reg == RED3) begin
         done_result = add_sum;
      end else begin
         case (op_reg)
            OP_ADD, OP_SUB: begin
               done_result = add_sum;
               done_ovfl   = add_ovfl;
            end
            OP_XOR:    done_result = rs_reg ^ rt_reg;
            OP_SLL:    done_result = rs_reg << imm_reg;
            OP_SRA:    done_result = unsigned'($signed(rs_reg) >>> imm_reg);
            OP_ROR:    done_result = ror_res;
            OP_PADDSB: begin
               done_result = padd_res;
               done_ovfl   = |padd_ovf;
            end
            default:   done_result = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         op_reg        <= OP_ADD;
         rs_reg        <= '0;
         rt_reg        <= '0;
         imm_reg       <= '0;
         t0_reg        <= '0;
         t1_reg        <= '0;
         result_reg    <= '0;
         ovfl_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid && in_ready_reg) begin
                  op_reg       <= alu_op_e'(opcode);
                  rs_reg       <= rs;
                  rt_reg       <= rt;
                  imm_reg      <= imm4;
                  in_ready_reg <= 1'b0;
                  state_reg    <= (alu_op_e'(opcode) == OP_RED) ? RED1 : EXEC;
               end
            end
            EXEC, RED3: begin
               result_reg    <= done_result;
               ovfl_reg      <= done_ovfl;
               out_valid_reg <= 1'b1;
               state_reg     <= DONE;
            end
            RED1: begin
               t0_reg    <= add_sum;
               state_reg <= RED2;
            end
            RED2: begin
               t1_reg    <= add_sum;
               state_reg <= RED3;
            end
            DONE: begin
               // in_ready stays low this cycle even while draining: no overlap.
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg     <= IDLE;
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
            end
         endcase
      end
   end

`ifdef ALU_SEQ_FLAGS_EN
   // {Z,V,N}: Z tracks every result, V/N only follow ADD/SUB.
   logic [2:0] flags_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_reg <= 3'b000;
      end else if (state_reg == EXEC || state_reg == RED3) begin
         flags_reg[2] <= (done_result == '0);
         if (state_reg == EXEC && (op_reg == OP_ADD || op_reg == OP_SUB)) begin
            flags_reg[1] <= done_ovfl;
            flags_reg[0] <= done_result[DW-1];
         end
      end
   end

   assign flags = flags_reg;
`else
   assign flags = 3'b000;
`endif

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign ovfl      = ovfl_reg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench: tb_alu_seq_ctrl
// Random and directed ops against an arithmetic reference model of alu_seq_ctrl.
// Honours ALU_SEQ_FLAGS_EN the same way the design does.
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  opcode = 3'd0;
   logic [15:0] rs = 16'd0;
   logic [15:0] rt = 16'd0;
   logic [3:0]  imm4 = 4'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] result;
   logic        ovfl;
   logic [2:0]  flags;

   alu_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .rs        (rs),
      .rt        (rt),
      .imm4      (imm4),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovfl      (ovfl),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_result = 16'd0;
   logic        exp_ovfl = 1'b0;
   logic [2:0]  exp_flags = 3'd0;
   logic [2:0]  mflags = 3'd0;
   bit          exp_armed = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: {ovfl, result} from plain signed integer arithmetic.
   function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] sh);
      int          s, x, y, l;
      logic [15:0] r;
      logic        o;
      logic [31:0] w;
      logic [3:0]  na, nb;
      r = 16'd0;
      o = 1'b0;
      s = 0;
      case (op)
         3'd0, 3'd1: begin
            if (op == 3'd0) s = int'($signed(a)) + int'($signed(b));
            else            s = int'($signed(a)) - int'($signed(b));
            if (s > 32767)       begin s = 32767;  o = 1'b1; end
            else if (s < -32768) begin s = -32768; o = 1'b1; end
            r = s[15:0];
         end
         3'd2: r = a ^ b;
         3'd3: begin
            s = int'($signed(a[15:8])) + int'($signed(a[7:0]))
              + int'($signed(b[15:8])) + int'($signed(b[7:0]));
            r = s[15:0];
         end
         3'd4: r = a << sh;
         3'd5: begin
            s = int'($signed(a)) >>> sh;
            r = s[15:0];
         end
         3'd6: begin
            w = {a, a} >> sh;
            r = w[15:0];
         end
         default: begin
            for (int i = 0; i < 4; i++) begin
               na = a[4*i +: 4];
               nb = b[4*i +: 4];
               x = int'($signed(na));
               y = int'($signed(nb));
               l = x + y;
               if (l > 7)       begin l = 7;  o = 1'b1; end
               else if (l < -8) begin l = -8; o = 1'b1; end
               r[4*i +: 4] = l[3:0];
            end
         end
      endcase
      return {o, r};
   endfunction

   function automatic logic [2:0] next_flags(input logic [2:0] op, input logic [15:0] r,
                                             input logic o, input logic [2:0] old);
      if (op == 3'd0 || op == 3'd1) return {(r == 16'd0), o, r[15]};
      return {(r == 16'd0), old[1:0]};
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 5))
         0:       return 16'h7FFF;
         1:       return 16'h8000;
         2:       return 16'h0000;
         3:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // Single compare process: whenever a result is presented it must match the model.
   always @(negedge clk) begin
      if (rst_n && exp_armed && out_valid) begin
         chk("result", {16'd0, result}, {16'd0, exp_result});
         chk("ovfl", {31'd0, ovfl}, {31'd0, exp_ovfl});
         chk("flags", {29'd0, flags}, {29'd0, exp_flags});
         chk("in_ready_while_valid", {31'd0, in_ready}, 32'd0);
      end
   end

   task automatic drive_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] sh);
      logic [16:0] m;
      @(negedge clk);
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      opcode = op;
      rs = a;
      rt = b;
      imm4 = sh;
      out_ready = 1'b0;
      m = model(op, a, b, sh);
      exp_result = m[15:0];
      exp_ovfl = m[16];
`ifdef ALU_SEQ_FLAGS_EN
      exp_flags = next_flags(op, m[15:0], m[16], mflags);
`else
      exp_flags = 3'b000;
`endif
      exp_armed = 1'b1;
      @(posedge clk);
      @(negedge clk);
      // Scramble inputs after accept; the latched op must be unaffected.
      in_valid = 1'b0;
      opcode = 3'($urandom);
      rs = 16'($urandom);
      rt = 16'($urandom);
      imm4 = 4'($urandom);
      chk("out_valid_at_accept", {31'd0, out_valid}, 32'd0);
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
   endtask

   task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] sh, input int hold);
      int c;
      drive_op(op, a, b, sh);
      c = 0;
      while (c < 8 && !out_valid) begin
         @(posedge clk);
         @(negedge clk);
         c++;
      end
      chk("latency", c, (op == 3'd3) ? 32'd3 : 32'd1);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("held_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("drain_valid", {31'd0, out_valid}, 32'd0);
      chk("drain_ready", {31'd0, in_ready}, 32'd1);
      mflags = exp_flags;
      exp_armed = 1'b0;
      $display("op=%0d rs=%h rt=%h imm=%0d hold=%0d -> result=%h ovfl=%b flags=%b",
               op, a, b, sh, hold, exp_result, exp_ovfl, exp_flags);
   endtask

   // Accept an op, let it advance n_edges more edges, then pull reset.
   task automatic reset_during(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                               input int n_edges, input string tag);
      drive_op(op, a, b, 4'd0);
      repeat (n_edges) @(posedge clk);
      @(negedge clk);
      #2;
      exp_armed = 1'b0;
      rst_n = 1'b0;
      #1;
      chk({"rst_valid_", tag}, {31'd0, out_valid}, 32'd0);
      chk({"rst_ready_", tag}, {31'd0, in_ready}, 32'd1);
      chk({"rst_result_", tag}, {16'd0, result}, 32'd0);
      chk({"rst_ovfl_", tag}, {31'd0, ovfl}, 32'd0);
      chk({"rst_flags_", tag}, {29'd0, flags}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mflags = 3'b000;
      @(posedge clk);
      @(negedge clk);
      chk({"post_rst_ready_", tag}, {31'd0, in_ready}, 32'd1);
      chk({"post_rst_valid_", tag}, {31'd0, out_valid}, 32'd0);
      $display("reset during %s: op=%0d rs=%h rt=%h discarded", tag, op, a, b);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_result", {16'd0, result}, 32'd0);
      chk("reset_ovfl", {31'd0, ovfl}, 32'd0);
      chk("reset_flags", {29'd0, flags}, 32'd0);

      // Hand-computed expectations that pin the model.
      chk("pin_add", {15'd0, model(3'd0, 16'h7FFF, 16'h0001, 4'd0)}, 32'h17FFF);
      chk("pin_sub", {15'd0, model(3'd1, 16'h8000, 16'h0001, 4'd0)}, 32'h18000);
      chk("pin_paddsb", {15'd0, model(3'd7, 16'h7777, 16'h1111, 4'd0)}, 32'h17777);
      chk("pin_red_pos", {15'd0, model(3'd3, 16'h7F7F, 16'h7F7F, 4'd0)}, 32'h001FC);
      chk("pin_red_neg", {15'd0, model(3'd3, 16'h8080, 16'h8080, 4'd0)}, 32'h0FE00);
      chk("pin_sra", {15'd0, model(3'd5, 16'h8000, 16'h0000, 4'd4)}, 32'h0F800);
      chk("pin_ror", {15'd0, model(3'd6, 16'h0001, 16'h0000, 4'd1)}, 32'h08000);
      chk("pin_flags_sub", {29'd0, next_flags(3'd1, 16'h8000, 1'b1, 3'b000)}, 32'h3);

      // Directed cases.
      do_op(3'd0, 16'h7FFF, 16'h0001, 4'd0, 0);
      do_op(3'd1, 16'h8000, 16'h0001, 4'd0, 2);
      do_op(3'd7, 16'h7777, 16'h1111, 4'd0, 1);
      do_op(3'd3, 16'h7F7F, 16'h7F7F, 4'd0, 0);
      do_op(3'd3, 16'h8080, 16'h8080, 4'd0, 1);
      do_op(3'd5, 16'h8000, 16'h0000, 4'd4, 5);
      do_op(3'd6, 16'h0001, 16'h0000, 4'd1, 0);
      do_op(3'd1, 16'h1234, 16'h1234, 4'd0, 0);
      do_op(3'd2, 16'hA5A5, 16'hFFFF, 4'd0, 0);

      reset_during(3'd3, 16'h7F7F, 16'h0101, 1, "red2");
      do_op(3'd0, 16'h0100, 16'h0023, 4'd0, 0);
      reset_during(3'd0, 16'h7FFF, 16'h7FFF, 1, "done");

      // Randomized traffic.
      for (int n = 0; n < 120; n++) begin
         do_op(3'($urandom_range(0, 7)), pick(), pick(), 4'($urandom),
               int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
